// File: rtl/wait_scheduler_pkg.sv
// rtl/wait_scheduler_pkg.sv - shared states, duration codes and timing defaults for wait_scheduler
package wait_scheduler_pkg;

  localparam int QUARTER_IMPL = 25000000;
  localparam int QUARTER_SIM  = 2;
  localparam int QCNT_W_IMPL  = 25;
  localparam int QCNT_W_SIM   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] DUR_Q1     = 2'b00;
  localparam logic [1:0] DUR_Q2     = 2'b01;
  localparam logic [1:0] DUR_S1     = 2'b10;
  localparam logic [1:0] DUR_S1_ALT = 2'b11;

  function automatic logic [2:0] quarters_of(input logic [1:0] code);
    logic [2:0] q;
    case (code)
      DUR_Q1:             q = 3'd1;
      DUR_Q2:             q = 3'd2;
      DUR_S1, DUR_S1_ALT: q = 3'd4;
      default:            q = 3'd4;
    endcase
    return q;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wait_scheduler_rr_arbiter4.sv
// rtl/wait_scheduler_rr_arbiter4.sv - combinational 4-way round-robin pick starting after last
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] next,
  output logic       valid
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    next  = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        next[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wait_scheduler.sv
// rtl/wait_scheduler.sv - shares one quarter-second timer among four requesters
module wait_scheduler
  import wait_scheduler_pkg::*;
#(
  parameter int QUARTER = QUARTER_IMPL,
  parameter int QCNT_W  = QCNT_W_IMPL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] dur,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       busy
);

  localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(QUARTER);

  state_t            state, state_n;
  logic [1:0]        chan, last, pick_idx;
  logic [2:0]        target, qcnt, qcnt_inc;
  logic [QCNT_W-1:0] cyc, cyc_next;
  logic [3:0]        pick, chan_oh;
  logic              pick_valid, quarter_end, abandon;

  rr_arbiter4 u_arb (
    .req   (req),
    .last  (last),
    .next  (pick),
    .valid (pick_valid)
  );

  assign pick_idx = onehot_idx(pick);
  assign chan_oh  = 4'b0001 << chan;

  // Cycle counter runs 1..QUARTER; a quarter ends on the edge that reaches QUARTER.
  assign cyc_next    = (cyc == QMAX) ? QCNT_W'(1) : cyc + QCNT_W'(1);
  assign quarter_end = (cyc_next == QMAX);
  assign qcnt_inc    = qcnt + 3'd1;
  assign abandon     = !req[chan];

  always_comb begin
    state_n = state;
    grant   = 4'b0000;
    done    = 4'b0000;
    busy    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) state_n = S_COUNT;
      end
      S_COUNT: begin
        grant = chan_oh;
        busy  = 1'b1;
        if (abandon) state_n = S_IDLE;
        else if (quarter_end && (qcnt_inc == target)) state_n = S_DONE;
      end
      S_DONE: begin
        grant   = chan_oh;
        done    = chan_oh;
        busy    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      chan   <= 2'd0;
      target <= 3'd0;
      qcnt   <= 3'd0;
      cyc    <= '0;
      last   <= 2'd3;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            chan   <= pick_idx;
            target <= quarters_of(dur[{pick_idx, 1'b0} +: 2]);
            cyc    <= '0;
            qcnt   <= 3'd0;
          end
        end
        S_COUNT: begin
          if (abandon) begin
            last <= chan;
            cyc  <= '0;
            qcnt <= 3'd0;
          end else begin
            cyc <= cyc_next;
            if (quarter_end) qcnt <= qcnt_inc;
          end
        end
        S_DONE: begin
          last <= chan;
          cyc  <= '0;
          qcnt <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wait_scheduler.sv
// tb/tb_wait_scheduler.sv - directed self-checking bench for wait_scheduler at QUARTER=2
module tb_wait_scheduler;
  import wait_scheduler_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] dur;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;

  int passed;
  int total;

  wait_scheduler #(
    .QUARTER (QUARTER_SIM),
    .QCNT_W  (QCNT_W_SIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dur   (dur),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d, input logic b);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".done"}, done, d);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, b});
  endtask

  // n granted cycles without done, then the DONE cycle
  task automatic run_wait(input string tag, input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out(tag, g, 4'b0000, 1'b1);
    end
    tick();
    expect_out({tag, ".done_cycle"}, g, g, 1'b1);
  endtask

  logic [3:0] order [5];

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    req    = 4'b0000;
    dur    = 8'h00;
    order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset holds outputs low even with requests present
    tick();
    expect_out("reset", 4'b0000, 4'b0000, 1'b0);
    req = 4'b1111;
    tick();
    expect_out("reset_req", 4'b0000, 4'b0000, 1'b0);
    req = 4'b0000;
    rst = 1'b1;
    tick();
    expect_out("idle", 4'b0000, 4'b0000, 1'b0);

    // single quarter on requester 0
    req = 4'b0001;
    dur = 8'b00_00_00_00;
    run_wait("q1", 4'b0001, 2);
    req = 4'b0000;
    tick();
    expect_out("q1_after", 4'b0000, 4'b0000, 1'b0);

    // one second, code 10 then code 11
    req = 4'b0001;
    dur = 8'b00_00_00_10;
    run_wait("s1_10", 4'b0001, 8);
    req = 4'b0000;
    tick();
    expect_out("s1_10_after", 4'b0000, 4'b0000, 1'b0);
    req = 4'b0001;
    dur = 8'b00_00_00_11;
    run_wait("s1_11", 4'b0001, 8);
    req = 4'b0000;
    tick();
    expect_out("s1_11_after", 4'b0000, 4'b0000, 1'b0);

    // round-robin from reset with all four held
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    dur = 8'b01_01_01_01;
    for (int k = 0; k < 5; k++) begin
      run_wait($sformatf("rr%0d", k), order[k], 4);
      if (k == 4) req = 4'b0000;
      tick();
      expect_out($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, 1'b0);
    end

    // abandon requester 1 after 3 cycles; pending requester 3 served next
    req = 4'b1010;
    dur = 8'b00_00_10_00;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("abn_cnt", 4'b0010, 4'b0000, 1'b1);
    end
    req = 4'b1000;
    tick();
    expect_out("abn_idle", 4'b0000, 4'b0000, 1'b0);
    run_wait("abn_next", 4'b1000, 2);
    req = 4'b0000;
    tick();
    expect_out("abn_after", 4'b0000, 4'b0000, 1'b0);

    // asynchronous reset mid-count on requester 2, then full restart
    req = 4'b0100;
    dur = 8'b00_10_00_00;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("rst_cnt", 4'b0100, 4'b0000, 1'b1);
    end
    #2 rst = 1'b0;
    #1 expect_out("rst_async", 4'b0000, 4'b0000, 1'b0);
    tick();
    expect_out("rst_hold", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    run_wait("rst_restart", 4'b0100, 8);
    req = 4'b0000;
    tick();
    expect_out("rst_after", 4'b0000, 4'b0000, 1'b0);

    // dur change after latching does not move completion
    req = 4'b0001;
    dur = 8'b00_00_00_00;
    tick();
    expect_out("dur_c1", 4'b0001, 4'b0000, 1'b1);
    dur = 8'hFF;
    tick();
    expect_out("dur_c2", 4'b0001, 4'b0000, 1'b1);
    tick();
    expect_out("dur_done", 4'b0001, 4'b0001, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("dur_after", 4'b0000, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wait_scheduler.md
WAIT_SCHEDULER -- requirements
Module: wait_scheduler

Interface
REQ-001 SHALL have parameter QUARTER, default 25000000, clock cycles per 0.25 s at 100 MHz (2 for sim).
REQ-002 SHALL have parameter QCNT_W, default 25, width of the cycle counter (2 for sim).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester wait request, level, held until done or abandoned.
REQ-006 SHALL have port dur  input  8  2 bits per requester (dur[2i+1:2i]): 00=0.25 s, 01=0.5 s, 10=1 s, 11=1 s.
REQ-007 SHALL have port grant  output  4  one-hot owner of the shared timer, all-zero when idle.
REQ-008 SHALL have port done  output  4  one-cycle pulse to the requester whose wait completed.
REQ-009 SHALL have port busy  output  1  high while the timer is owned (COUNT or DONE state).

Function
REQ-010 SHALL implement states IDLE, COUNT and DONE.
REQ-011 In IDLE with req != 0, SHALL select one requester by round-robin, searching from (last served + 1) mod 4.
- Last served SHALL be 3 after reset, so requester 0 wins first.
REQ-012 On the selection edge, SHALL latch channel and target quarters (1/2/4 from dur), clear counters and enter COUNT.
- grant is valid from the next cycle.
REQ-013 In COUNT, SHALL increment the cycle counter each clk from 1; at value QUARTER it wraps to 1 and increments the quarter counter.
REQ-014 SHALL leave COUNT for DONE on the edge where the quarter counter would reach target.
- Exactly target*QUARTER cycles with grant high.
REQ-015 In DONE (one cycle), SHALL assert done for the latched channel, keep grant and busy high, then return to IDLE and update last served.
REQ-016 If req of the granted channel falls during COUNT, SHALL abandon the wait.
- Return to IDLE next edge, no done pulse, last served still updated.
REQ-017 SHALL ignore changes on dur after latching, and req of non-granted channels while busy; those requesters stay pending.
REQ-018 A requester holding req high through DONE SHALL be treated as a new request, subject to round-robin.
REQ-019 SHALL never assert more than one grant bit or done bit at once; done SHALL be a subset of grant.
REQ-020 Counter arithmetic SHALL be unsigned; the cycle counter SHALL never exceed QUARTER; the quarter counter is 3 bits.

Reset
REQ-021 Asserting rst (low) at any time SHALL asynchronously force IDLE, grant=0, done=0, busy=0, counters=0, last served=3.
REQ-022 A wait in progress at reset SHALL be dropped without a done pulse.
REQ-023 After rst releases, the first selection SHALL occur on the first clk edge with req != 0.

Structure
REQ-024 State encodings, duration codes (00/01/10/11) and the quarter-target mapping SHALL live in a shared package.
- QUARTER sim/impl defaults SHALL also live in that package.
REQ-025 The round-robin pointer search SHALL be one sub-module, rr_arbiter4 (req, last, next one-hot, valid), combinational plus no state.

Verification (QUARTER=2)
REQ-026 Reset, then req=0001, dur=00 -> grant=0001 for 2 cycles, then done=0001 for 1 cycle, busy low after.
REQ-027 req=0001, dur=10 (1 s) -> grant high 8 cycles, done pulse in cycle 9, duration 11 gives identical timing.
REQ-028 req=1111 held, all dur=01 -> grants in order 0001, 0010, 0100, 1000, 0001, with 4+1 cycles per grant plus the IDLE selection cycle.
REQ-029 req=0010, dur=10, drop req after 3 granted cycles -> IDLE next edge, no done, next pending requester granted.
REQ-030 rst low mid-COUNT of requester 2 -> outputs 0 immediately, no done; after release with req=0100, grant restarts full duration.
REQ-031 dur changed during COUNT for the granted channel -> completion time unchanged from latched value.
